// File: rtl/sr_readout_pkg.sv
// sr_readout_pkg: FSM states, register offsets and bit positions shared by the readout controller
package sr_readout_pkg;
   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DATA   = 2'd2;
   localparam int START   = 0;
   localparam int IRQ_EN  = 1;
   localparam int BUSY    = 0;
   localparam int VALID   = 1;
   localparam int OVERRUN = 2;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, resets to 0
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta, r_q;
   always_ff @(posedge i_clk) begin
      if (i_rst) {r_q, r_meta} <= 2'b00;
      else {r_q, r_meta} <= {r_meta, i_d};
   end
   assign o_q = r_q;
endmodule

// File: rtl/sr_readout_ctrl.sv
// sr_readout_ctrl: clocks a serial shift register out MSB first and exposes the word over Wishbone
module sr_readout_ctrl
   import sr_readout_pkg::*;
#(
   parameter int          DATA_W    = 16,
   parameter int          DIV       = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        shift_clk_o,
   input  logic        sr_in,
   output logic        irq_o
);
   localparam int CW = $clog2(DATA_W + 1);
   localparam int DW = $clog2(DIV);
   state_t r_state, w_next;
   logic [DW-1:0] r_div;
   logic [CW-1:0] r_bitcnt;
   logic [DATA_W-1:0] r_shreg, r_data;
   logic [31:0] r_dat, w_rdata;
   logic [1:0] w_off;
   logic r_ack, r_irq, r_irq_en, r_busy, r_valid, r_overrun;
   logic w_sr, w_acc, w_wr, w_start, w_rd_data, w_div_end, w_bit_end, w_unused;

   sync_2ff u_sync (.i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_d(sr_in), .o_q(w_sr));

   assign w_unused  = ^{wbs_dat_i[31:2], wbs_sel_i[3:1], wbs_adr_i[1:0]};
   assign w_off     = wbs_adr_i[3:2];
   // Requests are refused in the ack cycle, so an ack never lasts two cycles
   assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign w_wr      = w_acc & wbs_we_i & (w_off == OFF_CTRL) & wbs_sel_i[0];
   assign w_start   = w_wr & wbs_dat_i[START] & (r_state == S_IDLE);
   assign w_rd_data = w_acc & ~wbs_we_i & (w_off == OFF_DATA);
   assign w_div_end = r_div == DW'(DIV - 1);
   assign w_bit_end = r_bitcnt == CW'(DATA_W - 1);
   assign w_rdata   = (w_off == OFF_CTRL)   ? {30'd0, r_irq_en, 1'b0} :
                      (w_off == OFF_STATUS) ? {29'd0, r_overrun, r_valid, r_busy} :
                      (w_off == OFF_DATA)   ? 32'(r_data) : 32'd0;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = S_LOW;
         S_LOW:   if (w_div_end) w_next = S_HIGH;
         S_HIGH:  if (w_div_end) w_next = w_bit_end ? S_DONE : S_LOW;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack     <= 1'b0;
         r_dat     <= '0;
         r_irq     <= 1'b0;
         r_irq_en  <= 1'b0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_div     <= '0;
         r_bitcnt  <= '0;
         r_shreg   <= '0;
         r_data    <= '0;
      end else begin
         r_ack  <= w_acc;
         r_dat  <= w_acc ? w_rdata : 32'd0;
         r_irq  <= (r_state == S_DONE) & r_irq_en;
         r_busy <= (r_state == S_LOW) | (r_state == S_HIGH);
         r_div  <= ((r_state == S_LOW || r_state == S_HIGH) && !w_div_end) ? r_div + 1'b1 : '0;
         if (w_wr) r_irq_en <= wbs_dat_i[IRQ_EN];
         if (r_state == S_IDLE) r_bitcnt <= '0;
         else if (r_state == S_HIGH && w_div_end) begin
            r_shreg  <= {r_shreg[DATA_W-2:0], w_sr};
            r_bitcnt <= r_bitcnt + 1'b1;
         end
         if (w_rd_data) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end
         // Frame completion is ordered after the read-clear so the set wins a same-cycle race
         if (r_state == S_DONE) begin
            r_data    <= r_shreg;
            r_overrun <= r_valid;
            r_valid   <= 1'b1;
         end
      end
   end

   assign wbs_ack_o   = r_ack;
   assign wbs_dat_o   = r_dat;
   assign irq_o       = r_irq;
   assign shift_clk_o = r_state == S_HIGH;
endmodule
